// File: rtl/coreport_arbiter.sv
// coreport_arbiter: round-robin Wishbone arbiter with bus lock and stall watchdog in front of the coreport GPIO slave
module coreport_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst_n,
  input  logic [NUM_MASTERS*32-1:0]    m_adr_i,
  input  logic [NUM_MASTERS*WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  output logic [WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [31:0]                  s_adr_o,
  output logic [WIDTH-1:0]             s_dat_o,
  output logic                         s_we_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  input  logic [WIDTH-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_o
);
  localparam int OW = $clog2(NUM_MASTERS);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [OW-1:0] owner, last_owner, nxt;
  logic [CW-1:0] wd_cnt;
  logic busy, own_stb, wd_fire;
  // scan from farthest to nearest so the requester right after last_owner wins
  always_comb begin
    int j;
    j = 0;
    nxt = last_owner;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      j = (int'(last_owner) + i) % NUM_MASTERS;
      if (m_cyc_i[OW'(j)]) nxt = OW'(j);
    end
  end
  assign busy    = state == GRANT;
  assign own_stb = busy & m_stb_i[owner];
  // an ack landing on the limit cycle beats the watchdog
  assign wd_fire = (TIMEOUT != 0) && own_stb && !s_ack_i && (int'(wd_cnt) == TIMEOUT - 1);
  assign grant_o = busy ? NUM_MASTERS'(1) << owner : '0;
  assign owner_o = owner;
  assign s_adr_o = busy ? m_adr_i[owner*32 +: 32] : '0;
  assign s_dat_o = busy ? m_dat_i[owner*WIDTH +: WIDTH] : '0;
  assign s_we_o  = busy & m_we_i[owner];
  assign s_cyc_o = busy & m_cyc_i[owner] & ~wd_fire;
  assign s_stb_o = own_stb & ~wd_fire;
  assign m_ack_o = grant_o & {NUM_MASTERS{s_ack_i & s_stb_o}};
  assign m_err_o = grant_o & {NUM_MASTERS{(s_err_i & s_stb_o) | wd_fire}};
  assign m_dat_o = s_dat_i;
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_MASTERS - 1);
      wd_cnt     <= '0;
    end else begin
      wd_cnt <= (own_stb && !s_ack_i && !s_err_i && !wd_fire) ? wd_cnt + CW'(1) : '0;
      if (state == IDLE) begin
        if (|m_cyc_i) begin
          owner <= nxt;
          state <= GRANT;
        end
      end else if (!m_cyc_i[owner] || wd_fire) begin
        state      <= IDLE;
        last_owner <= owner;
      end
    end
  end
endmodule
